tff_mod_counter: RTL and testbench

- Parametrised synchronous modulo up/down counter.
- Built as a bank of WIDTH toggle-flop cells. Each cell's T input is driven by a computed toggle vector (next = count ^ t_vec).
- Generalises the single T flip-flop to an N-bit counter with modulus, direction, parallel load, and terminal-count/wrap outputs for cascading.
- Used as a prescaler/timer building block in the same datapath as the existing flop primitives.

---
 rtl/tff_mod_counter_pkg.sv | 24 ++
 rtl/tff_mod_counter_cell.sv | 31 +++
 rtl/tff_mod_counter.sv | 106 ++++++++++
 tb/tb_tff_mod_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tff_mod_counter_pkg.sv
// Shared definitions for the toggle-flop modulo counter.
//   dir_e        : count direction encoding (DIR_UP / DIR_DN)
//   is_terminal  : true when the next step in the given direction must wrap
//   clamp_load   : limits a parallel-load value to the legal range 0..modulus-1
package cnt_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  function automatic logic is_terminal(input int unsigned count,
                                       input logic        up,
                                       input int unsigned modulus);
    if (up == DIR_UP) return (count == modulus - 1);
    else              return (count == 0);
  endfunction

  function automatic int unsigned clamp_load(input int unsigned val,
                                             input int unsigned modulus);
    return (val >= modulus) ? (modulus - 1) : val;
  endfunction

endpackage

// File: rtl/tff_mod_counter_cell.sv
// Single toggle flip-flop with synchronous active-low reset and parallel load.
//   clk     : clock, rising edge
//   rst     : synchronous reset, active low
//   rst_val : value taken on reset
//   ld      : load strobe (beats toggle)
//   ld_d    : load data
//   t       : toggle request
//   q, qbar : stored bit and its complement
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic ld,
  input  logic ld_d,
  input  logic t,
  output logic q,
  output logic qbar
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (!rst)     r_q <= rst_val;
    else if (ld)  r_q <= ld_d;
    else if (t)   r_q <= ~r_q;
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo up/down counter built from a bank of toggle-flop cells.
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low
//   en       : advance one step this edge
//   up       : 1 = increment, 0 = decrement
//   load     : parallel load strobe (beats en)
//   load_val : value to load; out-of-range values clamp to MODULUS-1
//   count    : current count (cell flop outputs)
//   tc       : terminal count, combinational, intended as the next stage's en
//   wrap     : one-cycle pulse the cycle after a wrap edge
//   load_err : one-cycle pulse the cycle after an out-of-range load
module tff_mod_counter
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 10,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);

  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 ||
      MODULUS > (32'd1 << WIDTH) || RESET_VAL >= MODULUS) begin : g_bad_params
    $error("tff_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qbar;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_ld_d;
  logic [WIDTH-1:0] w_wrap_target;
  logic             w_term;
  logic             w_load_oor;
  logic             r_wrap;
  logic             r_load_err;

  assign w_term        = is_terminal(32'(w_q), up, MODULUS);
  assign w_wrap_target = (up == DIR_UP) ? '0 : MAX_VAL;
  assign w_load_oor    = (32'(load_val) >= MODULUS);
  assign w_ld_d        = WIDTH'(clamp_load(32'(load_val), MODULUS));

  // Non-terminal steps use the classic ripple-AND toggle chain (over q for up,
  // over qbar for down); a terminal step toggles exactly the bits that differ
  // from the wrap target, which also covers MODULUS == 2^WIDTH.
  always_comb begin
    logic up_run;
    logic dn_run;
    w_t    = '0;
    up_run = 1'b1;
    dn_run = 1'b1;
    if (w_term) begin
      w_t = w_q ^ w_wrap_target;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        w_t[i] = (up == DIR_UP) ? up_run : dn_run;
        up_run = up_run & w_q[i];
        dn_run = dn_run & w_qbar[i];
      end
    end
    if (!en) w_t = '0;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VEC[g]),
      .ld      (load),
      .ld_d    (w_ld_d[g]),
      .t       (w_t[g]),
      .q       (w_q[g]),
      .qbar    (w_qbar[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_wrap     <= 1'b0;
      r_load_err <= w_load_oor;
    end else begin
      r_wrap     <= en & w_term;
      r_load_err <= 1'b0;
    end
  end

  assign count    = w_q;
  assign tc       = en & w_term;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_tff_mod_counter.sv
module tb_tff_mod_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tc, wrap, load_err;

  logic       en16, up16, load16;
  logic [3:0] load_val16, count16;
  logic       tc16, wrap16, load_err16;

  logic       ce, cload;
  logic [3:0] c1, c2;
  logic       c1_tc, c2_tc, c1_wrap, c2_wrap, c1_err, c2_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .up(up16), .load(load16), .load_val(load_val16),
    .count(count16), .tc(tc16), .wrap(wrap16), .load_err(load_err16)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_c1 (
    .clk(clk), .rst(rst), .en(ce), .up(1'b1), .load(cload), .load_val(4'd0),
    .count(c1), .tc(c1_tc), .wrap(c1_wrap), .load_err(c1_err)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_c2 (
    .clk(clk), .rst(rst), .en(c1_tc), .up(1'b1), .load(cload), .load_val(4'd0),
    .count(c2), .tc(c2_tc), .wrap(c2_wrap), .load_err(c2_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset_up();
    rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd7;
    tick(); tick();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b exp 0", wrap); end
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL reset_load_err got %b exp 0", load_err); end
    rst = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      tests++; if (count !== 4'(k % 10)) begin fails++; $display("FAIL up_count k=%0d got %0d exp %0d", k, count, k % 10); end
      tests++; if (tc !== ((k % 10) == 9)) begin fails++; $display("FAIL up_tc k=%0d got %b exp %b", k, tc, (k % 10) == 9); end
      tests++; if (wrap !== (k == 10)) begin fails++; $display("FAIL up_wrap k=%0d got %b exp %b", k, wrap, k == 10); end
      tick();
    end
  endtask

  task automatic test_down_wrap();
    do_load(4'd0);
    en = 1'b1; up = 1'b0; #1;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL dn_load got %0d exp 0", count); end
    tests++; if (tc !== 1'b1) begin fails++; $display("FAIL dn_tc0 got %b exp 1", tc); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL dn_wrap_on_load got %b exp 0", wrap); end
    tick();
    tests++; if (count !== 4'd9) begin fails++; $display("FAIL dn_wrap_count got %0d exp 9", count); end
    tests++; if (wrap !== 1'b1) begin fails++; $display("FAIL dn_wrap_pulse got %b exp 1", wrap); end
    tests++; if (tc !== 1'b0) begin fails++; $display("FAIL dn_tc9 got %b exp 0", tc); end
    tick();
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL dn_count8 got %0d exp 8", count); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL dn_wrap_drop got %b exp 0", wrap); end
  endtask

  task automatic test_load_range();
    do_load(4'd13);
    tests++; if (count !== 4'd9) begin fails++; $display("FAIL oor_clamp got %0d exp 9", count); end
    tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL oor_err got %b exp 1", load_err); end
    tick();
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL oor_err_drop got %b exp 0", load_err); end
    tests++; if (count !== 4'd9) begin fails++; $display("FAIL oor_hold got %0d exp 9", count); end
    do_load(4'd5);
    tests++; if (count !== 4'd5) begin fails++; $display("FAIL ld5 got %0d exp 5", count); end
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL ld5_err got %b exp 0", load_err); end
    do_load(4'd10);
    tests++; if (count !== 4'd9) begin fails++; $display("FAIL ld10_clamp got %0d exp 9", count); end
    tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL ld10_err got %b exp 1", load_err); end
    do_load(4'd9);
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL ld9_err got %b exp 0", load_err); end
  endtask

  task automatic test_simultaneous();
    do_load(4'd9);
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd3; #1;
    tests++; if (tc !== 1'b1) begin fails++; $display("FAIL sim_tc got %b exp 1", tc); end
    tick();
    load = 1'b0; en = 1'b0;
    tests++; if (count !== 4'd3) begin fails++; $display("FAIL sim_load_count got %0d exp 3", count); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL sim_load_wrap got %b exp 0", wrap); end
    do_load(4'd9);
    rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd13;
    tick();
    rst = 1'b1; load = 1'b0; en = 1'b0;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL sim_rst_count got %0d exp 0", count); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL sim_rst_wrap got %b exp 0", wrap); end
    tests++; if (load_err !== 1'b0) begin fails++; $display("FAIL sim_rst_err got %b exp 0", load_err); end
  endtask

  task automatic test_reverse_hold();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'd5; exp_seq[1] = 4'd6; exp_seq[2] = 4'd5; exp_seq[3] = 4'd4;
    do_load(4'd4);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up = (k < 2);
      tick();
      tests++; if (count !== exp_seq[k]) begin fails++; $display("FAIL rev k=%0d got %0d exp %0d", k, count, exp_seq[k]); end
    end
    en = 1'b0; up = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (count !== 4'd4) begin fails++; $display("FAIL hold k=%0d got %0d exp 4", k, count); end
      tests++; if (tc !== 1'b0) begin fails++; $display("FAIL hold_tc k=%0d got %b exp 0", k, tc); end
      tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL hold_wrap k=%0d got %b exp 0", k, wrap); end
    end
  endtask

  task automatic test_full_range();
    load16 = 1'b1; load_val16 = 4'd15; en16 = 1'b0;
    tick();
    load16 = 1'b0; en16 = 1'b1; up16 = 1'b1; #1;
    tests++; if (count16 !== 4'd15) begin fails++; $display("FAIL m16_load got %0d exp 15", count16); end
    tests++; if (tc16 !== 1'b1) begin fails++; $display("FAIL m16_tc got %b exp 1", tc16); end
    tick();
    tests++; if (count16 !== 4'd0) begin fails++; $display("FAIL m16_wrap_count got %0d exp 0", count16); end
    tests++; if (wrap16 !== 1'b1) begin fails++; $display("FAIL m16_wrap got %b exp 1", wrap16); end
    up16 = 1'b0;
    tick();
    tests++; if (count16 !== 4'd15) begin fails++; $display("FAIL m16_dn_count got %0d exp 15", count16); end
    tests++; if (wrap16 !== 1'b1) begin fails++; $display("FAIL m16_dn_wrap got %b exp 1", wrap16); end
    en16 = 1'b0;
    tick();
    tests++; if (wrap16 !== 1'b0) begin fails++; $display("FAIL m16_wrap_drop got %b exp 0", wrap16); end
  endtask

  task automatic test_cascade();
    cload = 1'b1; ce = 1'b0;
    tick();
    cload = 1'b0; ce = 1'b1;
    for (int k = 0; k < 99; k++) begin
      tick();
      if (k == 44) begin
        tests++; if ({c2, c1} !== {4'd4, 4'd5}) begin fails++; $display("FAIL cas45 got %0d%0d exp 45", c2, c1); end
      end
    end
    tests++; if ({c2, c1} !== {4'd9, 4'd9}) begin fails++; $display("FAIL cas99 got %0d%0d exp 99", c2, c1); end
    tests++; if (c2_tc !== 1'b1) begin fails++; $display("FAIL cas99_tc2 got %b exp 1", c2_tc); end
    tick();
    ce = 1'b0;
    tests++; if ({c2, c1} !== {4'd0, 4'd0}) begin fails++; $display("FAIL cas00 got %0d%0d exp 00", c2, c1); end
    tests++; if (c1_wrap !== 1'b1) begin fails++; $display("FAIL cas_wrap1 got %b exp 1", c1_wrap); end
    tests++; if (c2_wrap !== 1'b1) begin fails++; $display("FAIL cas_wrap2 got %b exp 1", c2_wrap); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    en16 = 1'b0; up16 = 1'b1; load16 = 1'b0; load_val16 = '0;
    ce = 1'b0; cload = 1'b0;
    test_reset_up();
    test_down_wrap();
    test_load_range();
    test_simultaneous();
    test_reverse_hold();
    test_full_range();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
